// File: rtl/trap_sequencer_if.sv
// Signal bundle between the trap sequencer and the pipeline/CSR side.
// The master modport is the sequencer; the slave modport is the pipeline and CSR file.
interface trap_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            timer_irq;
  logic            ext_irq;
  logic            mie_mtie;
  logic            mie_meie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_in;
  logic [XLEN-1:0] ex_pc;
  logic            ex_valid;
  logic            stall;
  logic            is_mret;

  logic            mepc_wr;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_wr;
  logic [XLEN-1:0] mcause_wdata;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            busy;

  modport master (
    input  timer_irq, ext_irq, mie_mtie, mie_meie, mtvec, mepc_in, ex_pc, ex_valid, stall,
           is_mret,
    output mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, mstatus_mie, mstatus_mpie,
           pc_redirect, redirect_pc, flush, busy
  );

  modport slave (
    output timer_irq, ext_irq, mie_mtie, mie_meie, mtvec, mepc_in, ex_pc, ex_valid, stall,
           is_mret,
    input  mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, mstatus_mie, mstatus_mpie,
           pc_redirect, redirect_pc, flush, busy
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry and MRET return sequencer sitting beside EX.
// Owns mstatus.MIE/MPIE, writes mepc/mcause, and drives PC redirect plus flush.
module trap_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter bit          VECTORED   = 1'b1,
  parameter int unsigned TIMER_CODE = 7,
  parameter int unsigned EXT_CODE   = 11
) (
  input logic              clk,
  input logic              rst,
  trap_sequencer_if.master bus
);

  localparam int unsigned CodeW = 6;

  typedef enum logic [1:0] {StIdle, StTrap, StRet, StDrain} state_e;

  state_e           state_q, state_d;
  logic             mie_q, mie_d;
  logic             mpie_q, mpie_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [CodeW-1:0] code_q, code_d;

  logic            ok;
  logic            ext_take;
  logic            tmr_take;
  logic            take;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_off;

  assign ok       = bus.ex_valid & ~bus.stall;
  assign ext_take = bus.ext_irq & bus.mie_meie;
  assign tmr_take = bus.timer_irq & bus.mie_mtie;
  assign take     = mie_q & (ext_take | tmr_take);
  assign base     = bus.mtvec & ~XLEN'(3);
  assign vec_off  = VECTORED ? {{(XLEN-CodeW-2){1'b0}}, code_q, 2'b00} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      epc_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      epc_q   <= epc_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    epc_d   = epc_q;
    code_d  = code_q;

    unique case (state_q)
      StIdle: begin
        // MRET has priority; a pending interrupt is re-evaluated once DRAIN ends.
        if (ok && bus.is_mret) begin
          state_d = StRet;
        end else if (ok && take) begin
          state_d = StTrap;
          epc_d   = bus.ex_pc;
          code_d  = ext_take ? CodeW'(EXT_CODE) : CodeW'(TIMER_CODE);
        end
      end
      StTrap: begin
        mpie_d  = mie_q;
        mie_d   = 1'b0;
        state_d = StDrain;
      end
      StRet: begin
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
        state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while rst is sampled, even if the state is still TRAP/RET.
  always_comb begin
    bus.mepc_wr      = 1'b0;
    bus.mepc_wdata   = '0;
    bus.mcause_wr    = 1'b0;
    bus.mcause_wdata = '0;
    bus.pc_redirect  = 1'b0;
    bus.redirect_pc  = '0;
    bus.flush        = 1'b0;
    bus.busy         = 1'b0;
    if (!rst) begin
      bus.busy = (state_q != StIdle);
      unique case (state_q)
        StTrap: begin
          bus.mepc_wr      = 1'b1;
          bus.mepc_wdata   = epc_q;
          bus.mcause_wr    = 1'b1;
          bus.mcause_wdata = {1'b1, {(XLEN-1-CodeW){1'b0}}, code_q};
          bus.pc_redirect  = 1'b1;
          bus.redirect_pc  = base + vec_off;
          bus.flush        = 1'b1;
        end
        StRet: begin
          bus.pc_redirect = 1'b1;
          bus.redirect_pc = bus.mepc_in;
          bus.flush       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mstatus_mie  = mie_q;
  assign bus.mstatus_mpie = mpie_q;

endmodule
